seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller for the timer front panel. It time-multiplexes NUM_DIGITS BCD/hex nibbles onto one shared active-low segment bus and an active-low digit-select bus. Beyond a plain scanner it adds per-digit decimal point, per-digit enable, 16-level brightness PWM, hex glyphs and optional blinking. It runs on the system clock with an internal prescaler enable instead of derived clocks, and sits between the time-keeping counters and the board pins.

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_glyph_dec.sv | 13 +
 rtl/seg_scan_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants for the seven-segment scan controller.
//   GLYPH_ROM : 16 x 7-bit active-high glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_A..SEG_G, SEG_DP : bit positions inside the 8-bit segment bus Y
//   Y_IDLE, DIG_IDLE : inactive (dark) levels of the active-low pin buses
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Both pin buses are active-low, so "nothing lit" is all ones.
  localparam logic [7:0] Y_IDLE   = 8'hFF;
  localparam logic       DIG_IDLE = 1'b1;

  // Entry n is the glyph for nibble n (index 15 is written first).
  localparam logic [15:0][6:0] GLYPH_ROM = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage

// File: rtl/seg_glyph_dec.sv
// seg_glyph_dec -- combinational nibble to seven-segment glyph decoder.
//   nibble : in  4  BCD/hex value 0..F
//   seg    : out 7  active-high segments {g,f,e,d,c,b,a}
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH_ROM[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- multiplexed seven-segment scanner with per-digit dp,
// per-digit enable, 16-level brightness PWM and optional blinking.
//   clk         : in  1             system clock
//   rst         : in  1             asynchronous active-high reset
//   digits      : in  4*NUM_DIGITS  nibble i at [4i+3:4i], digit 0 rightmost
//   dp          : in  NUM_DIGITS    decimal point request, 1 = lit
//   digit_en    : in  NUM_DIGITS    1 = shown, 0 = dark but still scanned
//   brightness  : in  4             duty level 0..15
//   blink       : in  NUM_DIGITS    1 = digit blinks (needs SEG_BLINK_EN)
//   DIG         : out NUM_DIGITS    digit select, active-low
//   Y           : out 8             segments, active-low, Y[7] = dp
//   frame_start : out 1             one-cycle pulse when slot 0 begins
// Build option: define SEG_BLINK_EN to include the frame counter and the
// blink phase; without it the blink input is ignored.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 195312,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [NUM_DIGITS-1:0]   DIG,
  output logic [7:0]              Y,
  output logic                    frame_start
);

  // The prescaler is kept as a sub-phase pair (ph, sub_cnt) so that
  // ph = div_cnt / (SCAN_DIV/16) comes for free without a divider.
  localparam int SUB_LEN = SCAN_DIV / 16;
  localparam int SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("seg_scan_ctrl: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 32 || (SCAN_DIV % 16) != 0) begin : g_bad_scan_div
      $error("seg_scan_ctrl: SCAN_DIV must be a multiple of 16 and >= 32");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
      $error("seg_scan_ctrl: BLINK_FRAMES must be >= 1");
    end
  endgenerate

  logic [SUB_W-1:0]      sub_cnt_reg;
  logic [3:0]            ph_reg;
  logic [SLOT_W-1:0]     slot_reg;

  logic [3:0]            lat_nib_reg;
  logic                  lat_dp_reg;
  logic                  lat_en_reg;
  logic [3:0]            lat_bright_reg;

  logic [NUM_DIGITS-1:0] dig_reg;
  logic [7:0]            y_reg;
  logic                  frame_start_reg;

  logic [NUM_DIGITS-1:0] dig_next;
  logic [7:0]            y_next;
  logic                  frame_start_next;

  logic                  slot_start;
  logic                  sub_last;
  logic                  slot_last;
  logic                  blink_dark;
  logic                  lit;
  logic [6:0]            glyph;

  logic [3:0]            nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] slot_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib_arr[gi]  = digits[4*gi +: 4];
      assign slot_sel[gi] = (slot_reg == SLOT_W'(gi));
    end
  endgenerate

  assign slot_start = (sub_cnt_reg == '0) && (ph_reg == 4'd0);
  assign sub_last   = (sub_cnt_reg == SUB_W'(SUB_LEN - 1));
  assign slot_last  = (slot_reg == SLOT_W'(NUM_DIGITS - 1));

  // Prescaler and slot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_cnt_reg <= '0;
      ph_reg      <= 4'd0;
      slot_reg    <= '0;
    end else if (sub_last) begin
      sub_cnt_reg <= '0;
      ph_reg      <= ph_reg + 4'd1;
      if (ph_reg == 4'd15) begin
        slot_reg <= slot_last ? '0 : slot_reg + SLOT_W'(1);
      end
    end else begin
      sub_cnt_reg <= sub_cnt_reg + SUB_W'(1);
    end
  end

  // Per-slot snapshot: taken during the dark guard cycle so the whole lit
  // part of the slot is immune to input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_nib_reg    <= 4'd0;
      lat_dp_reg     <= 1'b0;
      lat_en_reg     <= 1'b0;
      lat_bright_reg <= 4'd0;
    end else if (slot_start) begin
      lat_nib_reg    <= nib_arr[slot_reg];
      lat_dp_reg     <= |(dp & slot_sel);
      lat_en_reg     <= |(digit_en & slot_sel);
      lat_bright_reg <= brightness;
    end
  end

`ifdef SEG_BLINK_EN
  // frame_cnt_reg counts frame starts since the last toggle; the phase
  // flips on the frame start that follows BLINK_FRAMES complete frames.
  localparam int FR_W = $clog2(BLINK_FRAMES + 1);

  logic [FR_W-1:0] frame_cnt_reg;
  logic            blink_on_reg;
  logic            lat_blink_reg;
  logic            frame_tick;

  assign frame_tick = slot_start && (slot_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
      lat_blink_reg <= 1'b0;
    end else begin
      if (slot_start) begin
        lat_blink_reg <= |(blink & slot_sel);
      end
      if (frame_tick) begin
        if (frame_cnt_reg == FR_W'(BLINK_FRAMES)) begin
          frame_cnt_reg <= FR_W'(1);
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FR_W'(1);
        end
      end
    end
  end

  assign blink_dark = lat_blink_reg & ~blink_on_reg;
`else
  logic unused_blink;
  assign unused_blink = |blink;
  assign blink_dark   = 1'b0;
`endif

  seg_glyph_dec u_glyph_dec (
    .nibble (lat_nib_reg),
    .seg    (glyph)
  );

  // The guard cycle at slot start is always dark so the previous digit's
  // segments never ghost onto the newly selected digit.
  assign lit = ~slot_start & lat_en_reg & (ph_reg <= lat_bright_reg) & ~blink_dark;

  always_comb begin
    dig_next         = {NUM_DIGITS{DIG_IDLE}};
    y_next           = Y_IDLE;
    frame_start_next = slot_start && (slot_reg == '0);
    if (lit) begin
      dig_next              = ~slot_sel;
      y_next[SEG_G:SEG_A]   = ~glyph;
      y_next[SEG_DP]        = ~lat_dp_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_reg         <= {NUM_DIGITS{DIG_IDLE}};
      y_reg           <= Y_IDLE;
      frame_start_reg <= 1'b0;
    end else begin
      dig_reg         <= dig_next;
      y_reg           <= y_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign DIG         = dig_reg;
  assign Y           = y_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl -- scoreboard bench for seg_scan_ctrl.
// A behavioural model pushes the expected pin state for every clock edge;
// the monitor pops it half a cycle later and compares it with the DUT.
// One line is printed per completed digit slot.
module tb_seg_scan_ctrl;

  localparam int ND    = 6;
  localparam int SD    = 32;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [23:0]   digits;
  logic [5:0]    dp;
  logic [5:0]    digit_en;
  logic [3:0]    brightness;
  logic [5:0]    blink;
  logic [5:0]    DIG;
  logic [7:0]    Y;
  logic          frame_start;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .dp          (dp),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .blink       (blink),
    .DIG         (DIG),
    .Y           (Y),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] dig;
    logic [7:0] y;
    logic       fs;
    int         slot;
    int         d;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Active-high glyphs {g,f,e,d,c,b,a} for 0..F.
  logic [6:0] glyph_t [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Model state: position inside the frame plus the per-slot snapshot.
  int         m_pos = 0;
  logic [3:0] m_nib = 4'd0;
  logic [3:0] m_bright = 4'd0;
  logic       m_dp = 1'b0;
  logic       m_en = 1'b0;
  logic       m_blink = 1'b0;
  int         m_frames = 0;
  logic       m_blink_on = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: expected output registered at each rising edge.
  initial begin : model_proc
    exp_t e;
    int   s;
    int   d;
    bit   lit;
    bit   bdark;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pos      = 0;
        m_nib      = 4'd0;
        m_bright   = 4'd0;
        m_dp       = 1'b0;
        m_en       = 1'b0;
        m_blink    = 1'b0;
        m_frames   = 0;
        m_blink_on = 1'b1;
        e.dig  = 6'h3F;
        e.y    = 8'hFF;
        e.fs   = 1'b0;
        e.slot = -1;
        e.d    = -1;
      end else begin
        s = m_pos / SD;
        d = m_pos % SD;
`ifdef SEG_BLINK_EN
        bdark = m_blink && !m_blink_on;
`else
        bdark = 1'b0;
`endif
        lit = (d != 0) && m_en && ((d / 2) <= int'(m_bright)) && !bdark;
        e.dig  = lit ? ~(6'b000001 << s) : 6'h3F;
        e.y    = lit ? {~m_dp, ~glyph_t[m_nib]} : 8'hFF;
        e.fs   = (m_pos == 0);
        e.slot = s;
        e.d    = d;
        if (d == 0) begin
          m_nib    = digits[4*s +: 4];
          m_dp     = dp[s];
          m_en     = digit_en[s];
          m_bright = brightness;
          m_blink  = blink[s];
        end
        if (m_pos == 0) begin
          m_frames++;
          m_blink_on = (((m_frames - 1) / BF) % 2) == 0;
        end
        m_pos = (m_pos + 1) % FRAME;
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: compare on the falling edge, one report line per slot.
  initial begin : monitor_proc
    exp_t e;
    int   lit_cnt;
    lit_cnt = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (!rst) begin
          check_val("dig", 32'(DIG), 32'(e.dig));
          check_val("y", 32'(Y), 32'(e.y));
          check_val("frame_start", 32'(frame_start), 32'(e.fs));
          check_val("dig_onehot", 32'($countones(~DIG) <= 1), 32'd1);
          if (e.d == 0) lit_cnt = 0;
          if (DIG != 6'h3F) lit_cnt++;
          if (e.d == SD - 1) begin
            $display("slot %0d: lit_cycles=%0d dig=%b y=%b", e.slot, lit_cnt, DIG, Y);
          end
        end
      end
    end
  end

  // Wait (bounded) until the model is about to process frame position target.
  task automatic wait_pos(input int target);
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (m_pos == target) return;
    end
    check_val("sync_timeout", 32'(m_pos), 32'(target));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    digits     = 24'h123456;
    dp         = 6'b000000;
    digit_en   = 6'b111111;
    brightness = 4'd15;
    blink      = 6'b000000;
    rst        = 1'b1;

    repeat (3) @(negedge clk);
    check_val("rst_dig", 32'(DIG), 32'h3F);
    check_val("rst_y", 32'(Y), 32'hFF);
    check_val("rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;

    // Full brightness scan of 123456.
    repeat (2 * FRAME) @(negedge clk);

    // Hex glyph plus decimal point on digit 0.
    digits[3:0] = 4'hA;
    dp[0]       = 1'b1;
    repeat (FRAME) @(negedge clk);

    // Minimum and middle duty.
    brightness = 4'd0;
    repeat (FRAME) @(negedge clk);
    brightness = 4'd7;
    repeat (FRAME) @(negedge clk);

    // Digit 0 disabled but still scanned.
    brightness = 4'd15;
    digit_en   = 6'b111110;
    repeat (FRAME) @(negedge clk);

    // Brightness change in the middle of slot 2.
    digit_en = 6'b111111;
    wait_pos(2 * SD + 10);
    brightness = 4'd0;
    repeat (FRAME) @(negedge clk);
    brightness = 4'd15;
    dp         = 6'b000000;

    // Blinking digit 1 across several blink periods.
    blink = 6'b000010;
    repeat (5 * FRAME) @(negedge clk);
    blink = 6'b000000;

    // Asynchronous reset in the middle of a lit slot.
    wait_pos(3 * SD + 10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_dig", 32'(DIG), 32'h3F);
    check_val("async_rst_y", 32'(Y), 32'hFF);
    check_val("async_rst_fs", 32'(frame_start), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME + SD) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
